// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor: one register per prefix level, a
// global-stall valid/ready pipeline, and carry-out / signed-overflow flags.
module ks_adder_pipe #(
  parameter  int WIDTH = 16,
  localparam int LOG2W = $clog2(WIDTH),
  localparam int LAT   = LOG2W + 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c0,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  // Handshake: input transfers on i_valid & o_ready, output transfers on
  // o_valid & i_ready. Every stage advances together when the output slot is
  // empty or being drained (adv); otherwise the whole pipe, valids included, holds.
  logic adv;
  assign adv     = ~o_valid | i_ready;
  assign o_ready = adv;

  logic [LAT-1:0] v;
  assign o_valid = v[LAT-1];

  logic [WIDTH-1:0] b_eff, p_in, g_in;
  logic             cin_in;

  // Carry-in is folded into the bit-0 generate, so after LOG2W levels every
  // G[i] is the true carry out of bit i including cin.
  always_comb begin
    b_eff  = i_sub ? ~i_b : i_b;
    cin_in = i_sub | i_c0;
    p_in   = i_a ^ b_eff;
    g_in   = i_a & b_eff;
    g_in[0] = g_in[0] | (p_in[0] & cin_in);
  end

  logic [WIDTH-1:0] g_q  [0:LOG2W];
  logic [WIDTH-1:0] p_q  [0:LOG2W-1];
  logic [WIDTH-1:0] ps_q [0:LOG2W];
  logic             cin_q[0:LOG2W];
  logic [WIDTH-1:0] g_n  [1:LOG2W];
  logic [WIDTH-1:0] p_n  [1:LOG2W-1];

  for (genvar k = 1; k <= LOG2W; k++) begin : g_lvl
    localparam int D = 1 << (k - 1);
    logic [WIDTH-1:0] gl;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_blk
        assign gl[i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i-D]);
      end else begin : g_pass
        assign gl[i] = g_q[k-1][i];
      end
    end
    assign g_n[k] = gl;
  end

  // Group propagate is only consumed by the next level, so the last level omits it.
  for (genvar k = 1; k < LOG2W; k++) begin : g_plvl
    localparam int D = 1 << (k - 1);
    logic [WIDTH-1:0] pl;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_blk
        assign pl[i] = p_q[k-1][i] & p_q[k-1][i-D];
      end else begin : g_pass
        assign pl[i] = p_q[k-1][i];
      end
    end
    assign p_n[k] = pl;
  end

  logic [WIDTH-1:0] sum_n, sum_q;
  logic             cout_q, ovf_q;

  assign sum_n = ps_q[LOG2W] ^ {g_q[LOG2W][WIDTH-2:0], cin_q[LOG2W]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v      <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int k = 0; k <= LOG2W; k++) begin
        g_q[k]   <= '0;
        ps_q[k]  <= '0;
        cin_q[k] <= 1'b0;
      end
      for (int k = 0; k < LOG2W; k++) begin
        p_q[k] <= '0;
      end
    end else if (adv) begin
      v        <= {v[LAT-2:0], i_valid};
      g_q[0]   <= g_in;
      p_q[0]   <= p_in;
      ps_q[0]  <= p_in;
      cin_q[0] <= cin_in;
      for (int k = 1; k <= LOG2W; k++) begin
        g_q[k]   <= g_n[k];
        ps_q[k]  <= ps_q[k-1];
        cin_q[k] <= cin_q[k-1];
      end
      for (int k = 1; k < LOG2W; k++) begin
        p_q[k] <= p_n[k];
      end
      sum_q  <= sum_n;
      cout_q <= g_q[LOG2W][WIDTH-1];
      ovf_q  <= g_q[LOG2W][WIDTH-1] ^ g_q[LOG2W][WIDTH-2];
    end
  end

  assign o_sum  = sum_q;
  assign o_cout = cout_q;
  assign o_ovf  = ovf_q;

endmodule
